// File: rtl/dff_response_checker.sv
// -----------------------------------------------------------------------------
// dff_response_checker
//
// Purpose:
//   Monitor for a single D flip-flop that has a synchronous active-high reset.
//   It watches the stimulus applied to the flop (d, flop reset) and the flop's
//   response (q, qb). It predicts q one clock ahead, flags mismatches as
//   one-cycle pulses, counts error cycles and checked cycles (both saturating),
//   and captures the checked-cycle count at the first failure.
//
// Optional feature:
//   DFF_CHK_QB_EN - when defined, qb is checked against ~q and complement
//                   errors feed err_cnt/fail. When undefined, qb is ignored
//                   and o_comp_err is always 0.
//
// Parameters:
//   CNT_W   width of the saturating error counter
//   CYC_W   width of the saturating checked-cycle counter and first-fail capture
//   WARMUP  edges spent in WARM after enable before comparing (1..15)
//
// Ports:
//   i_clk              rising-edge clock, shared with the monitored flop
//   i_rst              asynchronous reset, active low
//   i_en               1 = run; 0 = go to IDLE, counters hold
//   i_clr              synchronous clear of counters/flags, highest priority
//   i_d_mon            d applied to the flop
//   i_rst_mon          flop synchronous reset (active high)
//   i_q_mon            flop q
//   i_qb_mon           flop qb
//   o_data_err         1-cycle pulse: q differed from prediction
//   o_comp_err         1-cycle pulse: qb was not ~q
//   o_fail             sticky error flag
//   o_err_cnt          error cycles counted
//   o_chk_cnt          cycles compared
//   o_first_fail_cyc   o_chk_cnt value at the first error
//   o_state            00 IDLE, 01 WARM, 10 CHECK, 11 FAIL
//
// States:
//   IDLE  | disabled or just cleared; nothing compared
//   WARM  | prediction being primed; warm counter running down
//   CHECK | comparing every edge, no error seen yet in this run
//   FAIL  | comparing every edge, at least one error seen
// -----------------------------------------------------------------------------
module dff_response_checker #(
  parameter int CNT_W  = 8,
  parameter int CYC_W  = 16,
  parameter int WARMUP = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_d_mon,
  input  logic             i_rst_mon,
  input  logic             i_q_mon,
  input  logic             i_qb_mon,
  output logic             o_data_err,
  output logic             o_comp_err,
  output logic             o_fail,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [CYC_W-1:0] o_chk_cnt,
  output logic [CYC_W-1:0] o_first_fail_cyc,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WARM  = 2'b01,
    ST_CHECK = 2'b10,
    ST_FAIL  = 2'b11
  } state_t;

  // Out-of-range WARMUP values are clamped so the counter always terminates.
  localparam int WARM_CLAMP = (WARMUP < 1) ? 1 : ((WARMUP > 15) ? 15 : WARMUP);
  localparam logic [3:0]       WARM_LOAD = 4'(WARM_CLAMP);
  localparam logic [CNT_W-1:0] ERR_MAX   = {CNT_W{1'b1}};
  localparam logic [CYC_W-1:0] CYC_MAX   = {CYC_W{1'b1}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_warm_cnt;
  logic [3:0]       w_warm_cnt_nxt;
  logic             r_exp_q;
  logic             r_data_err;
  logic             r_comp_err;
  logic             r_fail;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CYC_W-1:0] r_chk_cnt;
  logic [CYC_W-1:0] r_first_fail;

  logic w_compare;
  logic w_data_mis;
  logic w_comp_mis;
  logic w_err;

  // A compare happens only in CHECK/FAIL while enabled; clr suppresses it so
  // a same-cycle error can never survive the clear.
  assign w_compare  = ((r_state == ST_CHECK) || (r_state == ST_FAIL)) && i_en && !i_clr;
  assign w_data_mis = w_compare && (i_q_mon != r_exp_q);

`ifdef DFF_CHK_QB_EN
  assign w_comp_mis = w_compare && (i_qb_mon == i_q_mon);
`else
  // qb is not observed in this build; the AND keeps the port consumed while
  // forcing the complement check off.
  assign w_comp_mis = i_qb_mon & 1'b0;
`endif

  assign w_err = w_data_mis || w_comp_mis;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= ST_IDLE;
      r_warm_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_warm_cnt <= w_warm_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_warm_cnt_nxt = r_warm_cnt;
    if (i_clr || !i_en) begin
      w_state_nxt    = ST_IDLE;
      w_warm_cnt_nxt = 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt    = ST_WARM;
          w_warm_cnt_nxt = WARM_LOAD;
        end
        ST_WARM: begin
          // Transition on the edge where the down-counter reaches zero.
          if (r_warm_cnt <= 4'd1) begin
            w_state_nxt    = ST_CHECK;
            w_warm_cnt_nxt = 4'd0;
          end else begin
            w_warm_cnt_nxt = r_warm_cnt - 4'd1;
          end
        end
        ST_CHECK: begin
          if (w_err) begin
            w_state_nxt = ST_FAIL;
          end
        end
        ST_FAIL: begin
          w_state_nxt = ST_FAIL;
        end
        default: begin
          w_state_nxt    = ST_IDLE;
          w_warm_cnt_nxt = 4'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Prediction register: tracks the flop's next q whenever the checker is on.
  // Because WARM lasts at least one edge, it is always refreshed before the
  // first compare of a new run.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_exp_q <= 1'b0;
    end else if (i_en) begin
      r_exp_q <= i_rst_mon ? 1'b0 : i_d_mon;
    end
  end

  // ---------------------------------------------------------------------------
  // Result pulses, counters and sticky flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_data_err   <= 1'b0;
      r_comp_err   <= 1'b0;
      r_fail       <= 1'b0;
      r_err_cnt    <= '0;
      r_chk_cnt    <= '0;
      r_first_fail <= '0;
    end else if (i_clr) begin
      r_data_err   <= 1'b0;
      r_comp_err   <= 1'b0;
      r_fail       <= 1'b0;
      r_err_cnt    <= '0;
      r_chk_cnt    <= '0;
      r_first_fail <= '0;
    end else begin
      r_data_err <= w_data_mis;
      r_comp_err <= w_comp_mis;
      if (w_compare && (r_chk_cnt != CYC_MAX)) begin
        r_chk_cnt <= r_chk_cnt + 1'b1;
      end
      if (w_err) begin
        r_fail <= 1'b1;
        if (r_err_cnt != ERR_MAX) begin
          r_err_cnt <= r_err_cnt + 1'b1;
        end
        // Capture the count before this cycle's increment.
        if (!r_fail) begin
          r_first_fail <= r_chk_cnt;
        end
      end
    end
  end

  assign o_data_err       = r_data_err;
  assign o_comp_err       = r_comp_err;
  assign o_fail           = r_fail;
  assign o_err_cnt        = r_err_cnt;
  assign o_chk_cnt        = r_chk_cnt;
  assign o_first_fail_cyc = r_first_fail;
  assign o_state          = r_state;

endmodule

// File: tb/tb_dff_response_checker.sv
// -----------------------------------------------------------------------------
// tb_dff_response_checker
//
// Directed bench. A behavioural flop (with stuck-at-0 and qb=q fault knobs)
// feeds the main checker instance; a second instance with CNT_W=3 watches an
// always-inverted q to exercise error-counter saturation.
// -----------------------------------------------------------------------------
module tb_dff_response_checker;

  logic clk;
  logic rst;
  logic en;
  logic en_sat;
  logic clr;
  logic d;
  logic rst_mon;
  logic stuck0;
  logic qb_eq;

  logic m_q = 1'b0;
  logic q_mon;
  logic qb_mon;
  logic q_sat;
  logic qb_sat;

  logic        data_err, comp_err, fail;
  logic [7:0]  err_cnt;
  logic [15:0] chk_cnt, first_fail_cyc;
  logic [1:0]  state;

  logic        s_data_err, s_comp_err, s_fail;
  logic [2:0]  s_err_cnt;
  logic [15:0] s_chk_cnt, s_first_fail_cyc;
  logic [1:0]  s_state;

  int n_chk = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Reference flop with synchronous active-high reset
  always @(posedge clk) m_q <= rst_mon ? 1'b0 : d;

  assign q_mon  = stuck0 ? 1'b0 : m_q;
  assign qb_mon = qb_eq ? q_mon : ~q_mon;
  assign q_sat  = ~m_q;
  assign qb_sat = m_q;

  dff_response_checker #(.CNT_W(8), .CYC_W(16), .WARMUP(1)) u_dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_en             (en),
    .i_clr            (clr),
    .i_d_mon          (d),
    .i_rst_mon        (rst_mon),
    .i_q_mon          (q_mon),
    .i_qb_mon         (qb_mon),
    .o_data_err       (data_err),
    .o_comp_err       (comp_err),
    .o_fail           (fail),
    .o_err_cnt        (err_cnt),
    .o_chk_cnt        (chk_cnt),
    .o_first_fail_cyc (first_fail_cyc),
    .o_state          (state)
  );

  dff_response_checker #(.CNT_W(3), .CYC_W(16), .WARMUP(1)) u_dut_sat (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_en             (en_sat),
    .i_clr            (clr),
    .i_d_mon          (d),
    .i_rst_mon        (rst_mon),
    .i_q_mon          (q_sat),
    .i_qb_mon         (qb_sat),
    .o_data_err       (s_data_err),
    .o_comp_err       (s_comp_err),
    .o_fail           (s_fail),
    .o_err_cnt        (s_err_cnt),
    .o_chk_cnt        (s_chk_cnt),
    .o_first_fail_cyc (s_first_fail_cyc),
    .o_state          (s_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; en = 1'b0; en_sat = 1'b0; clr = 1'b0;
    d = 1'b0; rst_mon = 1'b1; stuck0 = 1'b0; qb_eq = 1'b0;

    // ---------------- reset ----------------
    step(); step();
    check("rst_state",   32'(state), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_chk_cnt", 32'(chk_cnt), 32'd0);
    check("rst_fail",    32'(fail), 32'd0);
    check("rst_pulses",  32'({data_err, comp_err}), 32'd0);
    check("rst_first",   32'(first_fail_cyc), 32'd0);
    #20 rst = 1'b1;
    rst_mon = 1'b0;
    step();
    check("idle_hold", 32'(state), 32'd0);

    // ---------------- good flop sequence ----------------
    en = 1'b1; d = 1'b0; step();
    check("good_warm", 32'(state), 32'd1);
    d = 1'b0; step();
    check("good_check", 32'(state), 32'd2);
    check("good_nochk_in_warm", 32'(chk_cnt), 32'd0);
    d = 1'b1; step();
    check("good_de_0", 32'(data_err), 32'd0);
    check("good_chk_1", 32'(chk_cnt), 32'd1);
    rst_mon = 1'b1; d = 1'b0; step();
    check("good_de_1", 32'(data_err), 32'd0);
    rst_mon = 1'b0; d = 1'b1; step();
    check("good_de_2", 32'(data_err), 32'd0);
    d = 1'b1; step();
    check("good_de_3",  32'(data_err), 32'd0);
    check("good_err",   32'(err_cnt), 32'd0);
    check("good_fail",  32'(fail), 32'd0);
    check("good_state", 32'(state), 32'd2);
    check("good_chk",   32'(chk_cnt), 32'd4);
    en = 1'b0; step();
    check("en0_idle",     32'(state), 32'd0);
    check("en0_chk_hold", 32'(chk_cnt), 32'd4);

    // ---------------- q stuck at 0 ----------------
    clr = 1'b1; step(); clr = 1'b0;
    check("clr_chk", 32'(chk_cnt), 32'd0);
    stuck0 = 1'b1;
    en = 1'b1; d = 1'b0; step();
    d = 1'b0; step();
    d = 1'b1; step();
    check("stk_de_ok", 32'(data_err), 32'd0);
    rst_mon = 1'b1; d = 1'b0; step();
    check("stk_de_pulse", 32'(data_err), 32'd1);
    check("stk_fail",     32'(fail), 32'd1);
    check("stk_state",    32'(state), 32'd3);
    check("stk_first",    32'(first_fail_cyc), 32'd1);
    check("stk_err_1",    32'(err_cnt), 32'd1);
    rst_mon = 1'b0; d = 1'b1; step();
    check("stk_de_one_cycle", 32'(data_err), 32'd0);
    check("stk_fail_sticky",  32'(fail), 32'd1);
    d = 1'b1; step();
    check("stk_de_2",    32'(data_err), 32'd1);
    check("stk_err_2",   32'(err_cnt), 32'd2);
    check("stk_chk_4",   32'(chk_cnt), 32'd4);
    check("stk_first_h", 32'(first_fail_cyc), 32'd1);
    check("stk_state_f", 32'(state), 32'd3);

    // ---------------- clr in FAIL with en=1 (same-cycle error suppressed) ----
    clr = 1'b1; step(); clr = 1'b0;
    check("clr_err",   32'(err_cnt), 32'd0);
    check("clr_chk0",  32'(chk_cnt), 32'd0);
    check("clr_first", 32'(first_fail_cyc), 32'd0);
    check("clr_fail",  32'(fail), 32'd0);
    check("clr_state", 32'(state), 32'd0);
    check("clr_de",    32'(data_err), 32'd0);
    d = 1'b0; step();
    check("clr_rewarm", 32'(state), 32'd1);
    step();
    check("clr_recheck", 32'(state), 32'd2);
    step();
    check("clr_resume_chk", 32'(chk_cnt), 32'd1);
    check("clr_resume_de",  32'(data_err), 32'd0);
    en = 1'b0; step();
    stuck0 = 1'b0;

    // ---------------- qb equal to q ----------------
    clr = 1'b1; step(); clr = 1'b0;
    qb_eq = 1'b1;
    en = 1'b1; d = 1'b1; step();
    check("qb_warm_ce", 32'(comp_err), 32'd0);
    d = 1'b0; step();
    check("qb_enter_ce", 32'(comp_err), 32'd0);
    d = 1'b1; step();
`ifdef DFF_CHK_QB_EN
    check("qb_ce_1",  32'(comp_err), 32'd1);
    check("qb_err_1", 32'(err_cnt), 32'd1);
`else
    check("qb_ce_1",  32'(comp_err), 32'd0);
    check("qb_err_1", 32'(err_cnt), 32'd0);
`endif
    d = 1'b0; step();
    d = 1'b1; step();
    check("qb_de",  32'(data_err), 32'd0);
    check("qb_chk", 32'(chk_cnt), 32'd3);
`ifdef DFF_CHK_QB_EN
    check("qb_ce_3",    32'(comp_err), 32'd1);
    check("qb_err_3",   32'(err_cnt), 32'd3);
    check("qb_fail",    32'(fail), 32'd1);
    check("qb_state",   32'(state), 32'd3);
    check("qb_first",   32'(first_fail_cyc), 32'd0);
`else
    check("qb_ce_3",    32'(comp_err), 32'd0);
    check("qb_err_3",   32'(err_cnt), 32'd0);
    check("qb_fail",    32'(fail), 32'd0);
    check("qb_state",   32'(state), 32'd2);
`endif
    qb_eq = 1'b0;

    // ---------------- CNT_W=3 saturation ----------------
    en_sat = 1'b1; d = 1'b0; step();
    d = 1'b1; step();
    check("sat_check", 32'(s_state), 32'd2);
    for (int i = 0; i < 10; i++) begin
      d = ~d;
      step();
      if (i == 0) begin
        check("sat_err_first", 32'(s_err_cnt), 32'd1);
        check("sat_first",     32'(s_first_fail_cyc), 32'd0);
      end
      if (i == 6) check("sat_err_7", 32'(s_err_cnt), 32'd7);
    end
    check("sat_err_held", 32'(s_err_cnt), 32'd7);
    check("sat_chk",      32'(s_chk_cnt), 32'd10);
    check("sat_fail",     32'(s_fail), 32'd1);
    check("sat_state",    32'(s_state), 32'd3);
    check("sat_de",       32'(s_data_err), 32'd1);

    // ---------------- async reset mid-run ----------------
    @(posedge clk);
    #20 rst = 1'b0;
    #5;
    check("arst_state",  32'(state), 32'd0);
    check("arst_chk",    32'(chk_cnt), 32'd0);
    check("arst_err",    32'(err_cnt), 32'd0);
    check("arst_fail",   32'(fail), 32'd0);
    check("arst_pulses", 32'({data_err, comp_err}), 32'd0);
    check("arst_sat",    32'({s_fail, s_err_cnt, s_state}), 32'd0);
    check("arst_s_de",   32'(s_data_err), 32'd0);
    en = 1'b0; en_sat = 1'b0;
    step();
    #20 rst = 1'b1;
    step();
    check("arst_after_de",    32'({data_err, s_data_err}), 32'd0);
    check("arst_after_state", 32'(state), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
